// File: rtl/ha_token_rx.sv
// ha_token_rx -- receiving end of a credit-based token link.
//
// Buffers tokens pushed by an upstream transmitter in a DEPTH-entry FIFO and
// presents them to the consumer through a show-ahead valid/ready interface.
// Every freed slot is returned to the transmitter as a one-cycle credit pulse.
// After reset, DEPTH initial credits are issued before the head token is
// exposed to the consumer.
//
// Optional build macro: HA_TOKEN_RX_PARITY_EN adds even-parity checking of
// incoming tokens (tok_par / par_err ports).
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active low
//   tok_valid  token present on tok_data (no backpressure)
//   tok_data   incoming token
//   tok_par    even-parity bit for tok_data (HA_TOKEN_RX_PARITY_EN only)
//   cred_ret   one-cycle pulse per credit returned
//   out_valid  head token available
//   out_data   head token (show-ahead)
//   out_ready  consumer accepts head token
//   occupancy  number of stored tokens
//   init_done  initial credits fully issued
//   ovf_err    sticky; token arrived while full with no pop
//   par_err    sticky; token failed parity (HA_TOKEN_RX_PARITY_EN only)
//
// FSM:
//   state | meaning
//   INIT  | issuing the initial DEPTH credits, consumer side held off
//   RUN   | steady state, left only through reset
module ha_token_rx #(
  parameter int DATA_BW = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tok_valid,
  input  logic [DATA_BW-1:0]         tok_data,
`ifdef HA_TOKEN_RX_PARITY_EN
  input  logic                       tok_par,
  output logic                       par_err,
`endif
  output logic                       cred_ret,
  output logic                       out_valid,
  output logic [DATA_BW-1:0]         out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       init_done,
  output logic                       ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  // Room for pend + two events before saturation.
  localparam int SW = CW + 2;

  typedef enum logic {INIT, RUN} stateT;

  stateT             state, stateNext;
  logic [PW-1:0]     initCnt, initCntNext;
  logic [DATA_BW-1:0] mem [DEPTH];
  logic [PW-1:0]     wrPtr, rdPtr;
  logic [CW-1:0]     pend, pendNext;
  logic [SW-1:0]     pendSum;
  logic [1:0]        events;
  logic              isFull, pop, push, ovfHit, parOk, parBad, credNow;

  always_comb begin
    isFull    = (occupancy == CW'(DEPTH));
    out_valid = (state == RUN) && (occupancy != '0);
    out_data  = mem[rdPtr];
    init_done = (state == RUN);
    pop       = out_valid & out_ready;
`ifdef HA_TOKEN_RX_PARITY_EN
    parOk     = ~(^tok_data ^ tok_par);
`else
    parOk     = 1'b1;
`endif
    parBad    = tok_valid & ~parOk;
    push      = tok_valid & parOk & (~isFull | pop);
    ovfHit    = tok_valid & parOk & isFull & ~pop;
    // A rejected parity token never used its slot, so its credit goes back.
    events    = {1'b0, pop} + {1'b0, parBad};
    credNow   = (pend != '0);
    pendSum   = SW'(pend) + SW'(events) - SW'(credNow);
    pendNext  = (pendSum > SW'(DEPTH)) ? CW'(DEPTH) : pendSum[CW-1:0];
  end

  always_comb begin
    stateNext   = state;
    initCntNext = initCnt;
    if (state == INIT && credNow) begin
      initCntNext = initCnt + PW'(1);
      if (initCnt == PW'(DEPTH-1)) stateNext = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= INIT;
      initCnt <= '0;
    end else begin
      state   <= stateNext;
      initCnt <= initCntNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
      pend      <= CW'(DEPTH);
      cred_ret  <= 1'b0;
      ovf_err   <= 1'b0;
`ifdef HA_TOKEN_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      if (push) begin
        mem[wrPtr] <= tok_data;
        wrPtr      <= wrPtr + PW'(1);
      end
      if (pop) rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
      pend     <= pendNext;
      cred_ret <= credNow;
      if (ovfHit) ovf_err <= 1'b1;
`ifdef HA_TOKEN_RX_PARITY_EN
      if (parBad) par_err <= 1'b1;
`endif
    end
  end

endmodule
